// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: NOP encoding, next-PC select codes,
// primary opcodes and small address/select helpers.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    localparam logic [1:0]  PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0]  PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0]  PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0]  PC_SRC_RSVD   = 2'b11;

    localparam logic [5:0]  OP_RTYPE      = 6'h00;
    localparam logic [5:0]  OP_J          = 6'h02;
    localparam logic [5:0]  OP_BEQ        = 6'h04;
    localparam logic [5:0]  OP_LW         = 6'h23;
    localparam logic [5:0]  OP_SW         = 6'h2B;

    // Instruction addresses are always word aligned; drop the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // A redirect is a taken branch or a jump; the reserved code is sequential.
    function automatic logic is_redirect(input logic [1:0] sel);
        logic r;
        case (sel)
            PC_SRC_BRANCH: r = 1'b1;
            PC_SRC_JUMP:   r = 1'b1;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and target alignment.
// A redirect always wins over stall and over a missing instruction word.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_valid,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_s;

    // Wraps naturally modulo 2^32.
    assign pc_plus4_s = pc_q + 32'd4;

    // Next-PC priority: redirect, then stall hold, then fetch-miss hold, then +4.
    always_comb begin
        pc_d = pc_q;
        case (pc_src)
            PC_SRC_BRANCH: pc_d = word_align(branch_target);
            PC_SRC_JUMP:   pc_d = word_align(jump_target);
            default: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (!imem_valid) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
        endcase
    end

    // PC state register; reset discards any pending redirect or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_s;
    assign redirect = is_redirect(pc_src);

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register. The PC lives in
// pc_reg; this level owns the IF/ID latch and the fetched-instruction count.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_func,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    logic        redirect_s;
    logic        squash_s;

    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .imem_valid    (imem_valid),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc            (pc_s),
        .pc_plus4      (pc_plus4_s),
        .redirect      (redirect_s)
    );

    assign squash_s = flush | redirect_s;

    // IF/ID next state: squash, then stall hold, then bubble on miss, then latch.
    // id_pc4 is meaningless under a bubble and simply keeps its old value.
    always_comb begin
        id_instr_d    = id_instr_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        if (squash_s) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (stall) begin
            id_instr_d = id_instr_q;
            id_valid_d = id_valid_q;
        end else if (!imem_valid) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else begin
            id_instr_d    = imem_rdata;
            id_pc4_d      = pc_plus4_s;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // IF/ID pipeline register and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q    <= NOP_INSTR;
            id_pc4_q      <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_s;
    assign id_instr    = id_instr_q;
    assign id_pc4      = id_pc4_q;
    assign id_valid    = id_valid_q;
    assign id_opcode   = id_instr_q[31:26];
    assign id_func     = id_instr_q[5:0];
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage. The instruction memory model
// returns {6'h23, addr[25:0]} for every address.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_func;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    if_id_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .id_instr      (id_instr),
        .id_pc4        (id_pc4),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_func       (id_func),
        .fetch_count   (fetch_count)
    );

    // Instruction memory model.
    assign imem_rdata = {6'h23, imem_addr[25:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  pc_src;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        chk_pc4;
        logic        e_valid;
        logic [31:0] e_count;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic chk_pc4, input logic e_valid,
                               input logic [31:0] e_count);
        logic [31:0] ei;
        ei = e_instr;
        check32({tag, " imem_addr"}, imem_addr, e_pc);
        check32({tag, " id_instr"}, id_instr, e_instr);
        if (chk_pc4) check32({tag, " id_pc4"}, id_pc4, e_pc4);
        else         check32({tag, " id_pc4 unchanged-by-bubble skipped"}, 32'(id_valid), 32'(e_valid));
        check32({tag, " id_valid"}, 32'(id_valid), 32'(e_valid));
        check32({tag, " id_opcode"}, 32'(id_opcode), 32'(ei[31:26]));
        check32({tag, " id_func"}, 32'(id_func), 32'(ei[5:0]));
        check32({tag, " fetch_count"}, fetch_count, e_count);
    endtask

    initial begin
        //            stall flush  src     bt            jt            vld   pc            instr         pc4           chk   v     count
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0004, 32'h8C00_0000, 32'h0000_0004, 1'b1, 1'b1, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0008, 32'h8C00_0004, 32'h0000_0008, 1'b1, 1'b1, 32'd2};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_000C, 32'h8C00_0008, 32'h0000_000C, 1'b1, 1'b1, 32'd3};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0010, 32'h8C00_000C, 32'h0000_0010, 1'b1, 1'b1, 32'd4};
        // two stall cycles at PC=0x10
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0010, 32'h8C00_000C, 32'h0000_0010, 1'b1, 1'b1, 32'd4};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0010, 32'h8C00_000C, 32'h0000_0010, 1'b1, 1'b1, 32'd4};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0014, 32'h8C00_0010, 32'h0000_0014, 1'b1, 1'b1, 32'd5};
        // fetch miss: bubble, PC held, 0x14 fetched on the next cycle
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd5};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0018, 32'h8C00_0014, 32'h0000_0018, 1'b1, 1'b1, 32'd6};
        // branch to misaligned 0x43 with simultaneous stall
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0043, 32'h0,       1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd6};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0044, 32'h8C00_0040, 32'h0000_0044, 1'b1, 1'b1, 32'd7};
        // jump to misaligned 0x103 while the branch target is a decoy
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h0000_0800, 32'h0000_0103, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h0,       1'b0, 1'b0, 32'd7};
        // reserved select behaves as sequential
        vecs[12] = '{1'b0, 1'b0, 2'b11, 32'h0000_0800, 32'h0000_0900, 1'b1, 32'h0000_0104, 32'h8C00_0100, 32'h0000_0104, 1'b1, 1'b1, 32'd8};
        // flush alone: PC advances, IF/ID squashed
        vecs[13] = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0108, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd8};
        // flush with stall: PC held, IF/ID still squashed
        vecs[14] = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0108, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd8};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_010C, 32'h8C00_0108, 32'h0000_010C, 1'b1, 1'b1, 32'd9};
        // jump to top of memory, then wrap on a normal fetch
        vecs[16] = '{1'b0, 1'b0, 2'b10, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 32'd9};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h0000_0000, 32'h8FFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, 32'd10};

        rst_n         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        pc_src        = 2'b00;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        imem_valid    = 1'b1;

        repeat (2) @(negedge clk);
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall         = vecs[i].stall;
            flush         = vecs[i].flush;
            pc_src        = vecs[i].pc_src;
            branch_target = vecs[i].bt;
            jump_target   = vecs[i].jt;
            imem_valid    = vecs[i].valid;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                        vecs[i].chk_pc4, vecs[i].e_valid, vecs[i].e_count);
            @(negedge clk);
        end

        // Reset asserted between edges during a stall with a pending branch.
        stall         = 1'b1;
        flush         = 1'b0;
        pc_src        = 2'b01;
        branch_target = 32'h0000_0200;
        imem_valid    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check_state("rst_held", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        stall  = 1'b0;
        pc_src = 2'b00;
        #1;
        check32("post_rst addr", imem_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_state("first_fetch", 32'h0000_0004, 32'h8C00_0000, 32'h0000_0004, 1'b1, 1'b1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
